fetch: RTL

Instruction-fetch stage of the multi-cycle core. It owns the architectural PC register and is the receiving end of the write stage's pcenable/next_pc interface. On each enable pulse from the core controller it issues one instruction-memory read for the current PC, waits for the memory acknowledge, latches the instruction, and pulses done to hand off to decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared core definitions used by the fetch stage: NOP encoding, reset PC default
// and the fetch FSM state type.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the architectural PC, issues one imem read per
// enable pulse and hands the fetched instruction to decode with a done pulse.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    output logic               done,
    input  logic               pcenable,
    input  logic [31:0]        next_pc,
    output logic [31:0]        pc_out,
    output logic [31:0]        instr,
    output logic               misaligned,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] fa;
    logic        start_issue;
    logic        start_fault;
    logic        finish;

    // A same-cycle PC write from the write stage is bypassed into the fetch address.
    assign fa = pcenable ? next_pc : pc;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable && !done && !is_misaligned(fa)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable is ignored while busy and in the done cycle; the controller re-pulses.
    always_comb begin
        start_issue = 1'b0;
        start_fault = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !done) begin
                    if (is_misaligned(fa)) begin
                        start_fault = 1'b1;
                    end else begin
                        start_issue = 1'b1;
                    end
                end
            end
            WAIT: begin
                finish = imem_valid;
            end
            default: begin
                finish = 1'b0;
            end
        endcase
    end

    // The PC only ever changes through the write stage; an in-flight fetch keeps fetch_pc.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc <= RESET_PC;
        end else if (pcenable) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done       <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            fetch_pc   <= '0;
            instr      <= '0;
            pc_out     <= '0;
            misaligned <= 1'b0;
        end else begin
            done     <= start_fault | finish;
            imem_req <= start_issue;
            if (start_issue) begin
                imem_addr <= fa[IMEM_AW+1:2];
                fetch_pc  <= fa;
            end
            if (start_fault) begin
                instr      <= NOP_INSTR;
                pc_out     <= fa;
                misaligned <= 1'b1;
            end else if (finish) begin
                instr      <= imem_rdata;
                pc_out     <= fetch_pc;
                misaligned <= 1'b0;
            end
        end
    end

endmodule
